// File: rtl/esram_ahb_sched.sv
// AHB-Lite master sequencer for the eSRAM: one-shot config write after reset, then
// write-priority arbitration between the SDIO write and I2S read requesters.
module esram_ahb_sched #(
  parameter int unsigned ADDWID       = 14,
  parameter logic [31:0] ESRAM_BASE   = 32'h2000_0000,
  parameter logic [31:0] CFG_ADDR     = 32'h4003_8080,
  parameter logic [31:0] CFG_DATA     = 32'h0000_0000,
  parameter int unsigned STARTUP_DLY  = 100,
  parameter int unsigned MAX_WR_BURST = 4
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDWID-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDWID-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              cfg_done,
  output logic              busy,
  input  logic              HREADY,
  input  logic [31:0]       HRDATA,
  output logic [31:0]       HADDR,
  output logic [31:0]       HWDATA,
  output logic [1:0]        HTRANS,
  output logic              HWRITE
);

  localparam int unsigned CNTW = $clog2(STARTUP_DLY + 1);
  localparam int unsigned STKW = $clog2(MAX_WR_BURST + 1);
  localparam logic [CNTW-1:0] DLY_LAST = CNTW'(STARTUP_DLY - 1);
  localparam logic [STKW-1:0] STK_MAX  = STKW'(MAX_WR_BURST);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_INIT, S_CFG_A, S_CFG_D, S_ARB, S_ADDR, S_DATA
  } state_t;

  state_t          state;
  logic [CNTW-1:0] dly_cnt;
  logic [STKW-1:0] streak;
  logic [31:0]     wdata_q;

  logic        elig_wr, elig_rd, grant_wr, grant_rd;
  logic [31:0] wr_haddr, rd_haddr;

  // A requester is ignored in its own ack cycle so a lingering req cannot re-issue.
  always_comb begin
    elig_wr  = wr_req & ~wr_ack;
    elig_rd  = rd_req & ~rd_valid;
    grant_wr = elig_wr & ~(elig_rd & (streak == STK_MAX));
    grant_rd = ~grant_wr & elig_rd;
    wr_haddr = {ESRAM_BASE[31:16], 16'({wr_addr, 2'b00})};
    rd_haddr = {ESRAM_BASE[31:16], 16'({rd_addr, 2'b00})};
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_INIT;
      dly_cnt  <= '0;
      streak   <= '0;
      wdata_q  <= '0;
      HADDR    <= '0;
      HWDATA   <= '0;
      HTRANS   <= HT_IDLE;
      HWRITE   <= 1'b0;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      cfg_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      unique case (state)
        S_INIT: begin
          if (dly_cnt != DLY_LAST) begin
            dly_cnt <= dly_cnt + CNTW'(1);
          end else if (HREADY) begin
            HADDR  <= CFG_ADDR;
            HWRITE <= 1'b1;
            HTRANS <= HT_NONSEQ;
            state  <= S_CFG_A;
          end
        end
        S_CFG_A: begin
          if (HREADY) begin
            HTRANS <= HT_IDLE;
            HWDATA <= CFG_DATA;
            state  <= S_CFG_D;
          end
        end
        S_CFG_D: begin
          if (HREADY) begin
            cfg_done <= 1'b1;
            HWRITE   <= 1'b0;
            state    <= S_ARB;
          end
        end
        S_ARB: begin
          if (grant_wr) begin
            HADDR   <= wr_haddr;
            HWRITE  <= 1'b1;
            HTRANS  <= HT_NONSEQ;
            wdata_q <= wr_data;
            busy    <= 1'b1;
            streak  <= (streak == STK_MAX) ? STK_MAX : streak + STKW'(1);
            state   <= S_ADDR;
          end else if (grant_rd) begin
            HADDR  <= rd_haddr;
            HWRITE <= 1'b0;
            HTRANS <= HT_NONSEQ;
            busy   <= 1'b1;
            streak <= '0;
            state  <= S_ADDR;
          end else begin
            HTRANS <= HT_IDLE;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            HTRANS <= HT_IDLE;
            if (HWRITE) HWDATA <= wdata_q;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (HREADY) begin
            if (HWRITE) begin
              wr_ack <= 1'b1;
            end else begin
              rd_data  <= HRDATA;
              rd_valid <= 1'b1;
            end
            HWRITE <= 1'b0;
            busy   <= 1'b0;
            state  <= S_ARB;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_esram_ahb_sched.sv
// Bench for esram_ahb_sched: AHB slave stub, transfer scoreboard, vector table and
// hand sequences for startup, write-streak cap, lingering requests and mid-transfer reset.
module tb_esram_ahb_sched;

  localparam logic [31:0] CFG_ADDR = 32'h4003_8080;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0, HREADY = 1'b1;
  logic [13:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0, HRDATA = '0;
  logic        wr_ack, rd_valid, cfg_done, busy, HWRITE;
  logic [31:0] rd_data, HADDR, HWDATA;
  logic [1:0]  HTRANS;

  always #5 mclk = ~mclk;

  esram_ahb_sched #(.ADDWID(14), .STARTUP_DLY(100), .MAX_WR_BURST(4)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .cfg_done(cfg_done), .busy(busy),
    .HREADY(HREADY), .HRDATA(HRDATA), .HADDR(HADDR), .HWDATA(HWDATA),
    .HTRANS(HTRANS), .HWRITE(HWRITE)
  );

  int checks = 0, errors = 0;
  int wr_ack_cnt = 0, rd_valid_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  xfer_t       mon_e;
  logic        in_dp = 1'b0, dp_wr = 1'b0;
  logic [31:0] dp_data = '0;

  // Scoreboard side: every accepted address phase must match the next expected transfer.
  always @(negedge mclk) begin
    if (!reset_n) begin
      in_dp = 1'b0;
    end else begin
      if (wr_ack) wr_ack_cnt++;
      if (rd_valid) rd_valid_cnt++;
      if (in_dp && HREADY) begin
        if (dp_wr) chk("hwdata", HWDATA, dp_data);
        in_dp = 1'b0;
      end
      if (HTRANS == 2'b10) begin
        chk("no_nonseq_in_data_phase", 32'(in_dp), 32'd0);
        if (HREADY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got HADDR 0x%08h HWRITE %0d, required no transfer", HADDR, HWRITE);
          end else begin
            mon_e = exp_q.pop_front();
            chk("haddr", HADDR, mon_e.addr);
            chk("hwrite", 32'(HWRITE), 32'(mon_e.wr));
            in_dp   = 1'b1;
            dp_wr   = mon_e.wr;
            dp_data = mon_e.data;
          end
        end
      end
    end
  end

  // Releases reset now and follows the config write to cfg_done.
  task automatic startup(input string tag);
    exp_q.push_back(xfer_t'{1'b1, CFG_ADDR, 32'h0});
    reset_n = 1'b1;
    repeat (99) @(posedge mclk);
    #1;
    chk({tag, "_idle_at_99"}, 32'(HTRANS), 32'd0);
    @(posedge mclk); #1;
    chk({tag, "_cfg_htrans"}, 32'(HTRANS), 32'd2);
    chk({tag, "_cfg_haddr"}, HADDR, CFG_ADDR);
    chk({tag, "_cfg_hwrite"}, 32'(HWRITE), 32'd1);
    @(posedge mclk); #1;
    chk({tag, "_cfg_dphase_htrans"}, 32'(HTRANS), 32'd0);
    chk({tag, "_cfg_hwdata"}, HWDATA, 32'h0);
    chk({tag, "_cfg_done_early"}, 32'(cfg_done), 32'd0);
    @(posedge mclk); #1;
    chk({tag, "_cfg_done"}, 32'(cfg_done), 32'd1);
    chk({tag, "_hwrite_cleared"}, 32'(HWRITE), 32'd0);
  endtask

  task automatic do_xfer(input string name, input logic is_wr, input logic [13:0] a,
                         input logic [31:0] d, input logic [31:0] exp_haddr,
                         input int unsigned waits, input bit linger);
    int unsigned n = 0, w = 0;
    int wa0 = wr_ack_cnt, rv0 = rd_valid_cnt;
    bit done = 1'b0;
    exp_q.push_back(xfer_t'{is_wr, exp_haddr, is_wr ? d : 32'h0});
    HREADY = 1'b1;
    if (is_wr) begin wr_addr = a; wr_data = d; wr_req = 1'b1; end
    else begin rd_addr = a; HRDATA = d; rd_req = 1'b1; end
    while (!done && n < 40) begin
      @(posedge mclk); #1; n++;
      if (is_wr ? wr_ack : rd_valid) done = 1'b1;
      else if (busy && HTRANS == 2'b00 && w < waits) begin HREADY = 1'b0; w++; end
      else HREADY = 1'b1;
    end
    HREADY = 1'b1;
    chk({name, "_latency"}, n, 3 + waits);
    chk({name, "_busy_in_ack"}, 32'(busy), 32'd0);
    chk({name, "_hwrite_in_ack"}, 32'(HWRITE), 32'd0);
    if (!is_wr) chk({name, "_rd_data"}, rd_data, d);
    if (linger) begin @(posedge mclk); #1; end
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(posedge mclk); #1;
    chk({name, "_pulse_end"}, {30'b0, wr_ack, rd_valid}, 32'd0);
    chk({name, "_pulse_count"}, is_wr ? 32'(wr_ack_cnt - wa0) : 32'(rd_valid_cnt - rv0), 32'd1);
  endtask

  // Both requesters raised together; each drops its request in its own ack cycle.
  task automatic both(input string name, input logic [13:0] wa, input logic [31:0] wd,
                      input logic [31:0] wh, input logic [13:0] ra, input logic [31:0] rdd,
                      input logic [31:0] rh, input bit read_first);
    int unsigned n = 0, wr_at = 0, rd_at = 0;
    if (read_first) begin
      exp_q.push_back(xfer_t'{1'b0, rh, 32'h0});
      exp_q.push_back(xfer_t'{1'b1, wh, wd});
    end else begin
      exp_q.push_back(xfer_t'{1'b1, wh, wd});
      exp_q.push_back(xfer_t'{1'b0, rh, 32'h0});
    end
    wr_addr = wa; wr_data = wd; rd_addr = ra; HRDATA = rdd; HREADY = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1;
    while ((wr_at == 0 || rd_at == 0) && n < 40) begin
      @(posedge mclk); #1; n++;
      if (wr_ack) begin wr_at = n; wr_req = 1'b0; end
      if (rd_valid) begin rd_at = n; rd_req = 1'b0; end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk({name, "_read_first"}, 32'(rd_at != 0 && rd_at < wr_at), 32'(read_first));
    chk({name, "_span"}, n, 32'd6);
    chk({name, "_rd_data"}, rd_data, rdd);
    @(posedge mclk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] data;
    int unsigned waits;
    logic [31:0] exp_haddr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int unsigned n;
    int wa0;
    logic [31:0] last_rd;

    vecs[0] = '{1'b1, 14'h0005, 32'hA5A5_A5A5, 2, 32'h2000_0014};
    vecs[1] = '{1'b0, 14'h3FFF, 32'h1234_5678, 0, 32'h2000_FFFC};
    vecs[2] = '{1'b1, 14'h3FFF, 32'hDEAD_BEEF, 0, 32'h2000_FFFC};
    vecs[3] = '{1'b0, 14'h0000, 32'hCAFE_F00D, 3, 32'h2000_0000};
    vecs[4] = '{1'b1, 14'h1234, 32'h0BAD_F00D, 1, 32'h2000_48D0};
    vecs[5] = '{1'b0, 14'h2AAA, 32'h55AA_55AA, 0, 32'h2000_AAA8};

    repeat (3) @(posedge mclk);
    #1;
    chk("rst_ctrl", 32'({HTRANS, HWRITE, wr_ack, rd_valid, cfg_done, busy}), 32'd0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    startup("boot");

    last_rd = 32'h0;
    for (int i = 0; i < 6; i++) begin
      do_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
              vecs[i].exp_haddr, vecs[i].waits, 1'b0);
      if (vecs[i].wr) chk($sformatf("vec%0d_rd_data_held", i), rd_data, last_rd);
      else last_rd = vecs[i].data;
    end

    // Streak is 0 after the last read; five lone writes saturate it at the cap.
    for (int i = 0; i < 5; i++)
      do_xfer($sformatf("solo_wr%0d", i), 1'b1, 14'h0010 + 14'(i), 32'h1000_0000 + 32'(i),
              32'h2000_0040 + 32'(4 * i), 0, 1'b0);
    both("at_cap", 14'h0020, 32'h7777_0001, 32'h2000_0080,
         14'h0021, 32'h8888_0001, 32'h2000_0084, 1'b1);
    for (int i = 0; i < 2; i++)
      do_xfer($sformatf("solo2_wr%0d", i), 1'b1, 14'h0030 + 14'(i), 32'h2000_0000 + 32'(i),
              32'h2000_00C0 + 32'(4 * i), 0, 1'b0);
    both("below_cap", 14'h0040, 32'h7777_0002, 32'h2000_0100,
         14'h0041, 32'h8888_0002, 32'h2000_0104, 1'b0);

    do_xfer("linger_wr", 1'b1, 14'h0050, 32'h3C3C_3C3C, 32'h2000_0140, 0, 1'b1);
    do_xfer("linger_rd", 1'b0, 14'h0051, 32'hC3C3_C3C3, 32'h2000_0144, 1, 1'b1);
    repeat (4) @(posedge mclk);
    #1;

    exp_q.push_back(xfer_t'{1'b1, 32'h2000_0400, 32'h1122_3344});
    wr_addr = 14'h0100; wr_data = 32'h1122_3344; wr_req = 1'b1; HREADY = 1'b1;
    n = 0;
    while (!(busy && HTRANS == 2'b00) && n < 10) begin @(posedge mclk); #1; n++; end
    chk("rst_reach_data", n, 32'd2);
    HREADY = 1'b0;
    @(posedge mclk); #1;
    wa0 = wr_ack_cnt;
    reset_n = 1'b0;
    #1;
    chk("midrst_htrans", 32'(HTRANS), 32'd0);
    chk("midrst_busy_cfg", 32'({busy, cfg_done}), 32'd0);
    chk("midrst_haddr", HADDR, 32'h0);
    repeat (2) @(posedge mclk);
    #1;
    HREADY = 1'b1;
    chk("midrst_no_ack", 32'(wr_ack), 32'd0);
    startup("rerun");
    exp_q.push_back(xfer_t'{1'b1, 32'h2000_0400, 32'h1122_3344});
    n = 0;
    while (!wr_ack && n < 10) begin @(posedge mclk); #1; n++; end
    wr_req = 1'b0;
    chk("pending_wr_latency", n, 32'd3);
    @(posedge mclk); #1;
    chk("acks_across_reset", 32'(wr_ack_cnt - wa0), 32'd1);

    repeat (3) @(posedge mclk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
